// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: the receiver state encoding,
// oversampling constants and the bit positions within an 11-bit frame
// (start, D0..D7 LSB-first, parity, stop).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned OVERSAMPLE    = 16;  // mclkx16 cycles per bit
    localparam int unsigned SAMPLE_POINT  = 7;   // tick value at mid-bit
    localparam int unsigned DATA_BITS     = 8;

    // Frame bit indices, as counted from the start bit.
    localparam int unsigned BIT_START     = 0;
    localparam int unsigned BIT_LAST_DATA = BIT_START + DATA_BITS;
    localparam int unsigned BIT_STOP      = BIT_LAST_DATA + 2;

    // Explicit encodings keep the state register identical to the legacy block.
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// N-flop synchronizer bringing an asynchronous single-bit input into the clk
// domain. The flops reset to RESET_VAL so an idle-high line does not look
// like a start bit while coming out of reset.
//   clk  : destination clock
//   rst  : synchronous, active-high reset
//   d    : asynchronous input
//   q    : synchronized output (N cycles of latency)
// -----------------------------------------------------------------------------
module uart_sync #(
    parameter int unsigned N         = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {N{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[N-2:0], d};
        end
    end

    assign q = r_sync[N-1];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver for 11-bit frames (start, 8 data bits LSB-first, parity,
// stop) at OVERSAMPLE x oversampling. Each completed frame is loaded into a
// receive holding register with a ready flag and per-frame error flags; the
// host consumes it with a single-cycle read strobe.
//   mclkx16    : clock, OVERSAMPLE x baud
//   reset      : synchronous, active-high
//   rx         : asynchronous serial input, idle high
//   read       : single-cycle strobe, consumes the held byte
//   data       : receive holding register (never cleared by read)
//   rxrdy      : holding register contains an unread byte
//   parityerr  : parity mismatch on the held byte
//   framingerr : stop bit sampled low on the held byte
//   overrun    : a completed frame replaced an unread byte (held until read)
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter logic        PARITY_ODD = 1'b1
) (
    input  logic       mclkx16,
    input  logic       reset,
    input  logic       rx,
    input  logic       read,
    output logic [7:0] data,
    output logic       rxrdy,
    output logic       parityerr,
    output logic       framingerr,
    output logic       overrun
);

    import uart_pkg::*;

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned IW = $clog2(BIT_STOP + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    // Package sample point, rescaled if OVERSAMPLE is overridden.
    localparam logic [TW-1:0] TICK_MID  =
        TW'((SAMPLE_POINT * OVERSAMPLE) / uart_pkg::OVERSAMPLE);

    logic                 w_rx_s;
    logic                 w_sample;
    logic                 w_frame_done;
    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [TW-1:0]        r_tick;
    logic [IW-1:0]        r_bitidx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_perr;

    logic [7:0]           r_data;
    logic                 r_rxrdy;
    logic                 r_parityerr;
    logic                 r_framingerr;
    logic                 r_overrun;

    uart_sync #(
        .N         (2),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (mclkx16),
        .rst (reset),
        .d   (rx),
        .q   (w_rx_s)
    );

    // The tick counter starts from 0 on the detection edge, so reaching
    // TICK_MID lands on the middle of every bit of the frame.
    always_comb begin
        w_sample = 1'b0;
        if (r_tick == TICK_MID) begin
            case (r_state)
                RX_START, RX_DATA, RX_PARITY, RX_STOP: w_sample = 1'b1;
                default:                               w_sample = 1'b0;
            endcase
        end
        w_frame_done = w_sample && (r_state == RX_STOP);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_IDLE: begin
                if (!w_rx_s) w_state_nxt = RX_START;
            end
            RX_START: begin
                if (w_sample) w_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (w_sample && r_bitidx == IW'(BIT_LAST_DATA))
                    w_state_nxt = RX_PARITY;
            end
            RX_PARITY: begin
                if (w_sample) w_state_nxt = RX_STOP;
            end
            RX_STOP: begin
                // A low stop bit means the line may be held in break; wait
                // for it to return high before hunting for a new start bit.
                if (w_sample) w_state_nxt = w_rx_s ? RX_IDLE : RX_BREAK;
            end
            RX_BREAK: begin
                if (w_rx_s) w_state_nxt = RX_IDLE;
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge mclkx16) begin
        if (reset) begin
            r_state  <= RX_IDLE;
            r_tick   <= '0;
            r_bitidx <= IW'(BIT_START);
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_perr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == RX_IDLE || r_state == RX_BREAK) begin
                r_tick <= '0;
            end else if (r_tick == TICK_LAST) begin
                r_tick <= '0;
            end else begin
                r_tick <= r_tick + TW'(1);
            end

            if (r_state == RX_IDLE) begin
                r_bitidx <= IW'(BIT_START);
            end else if (w_sample) begin
                r_bitidx <= r_bitidx + IW'(1);
            end

            if (w_sample) begin
                case (r_state)
                    RX_START: begin
                        r_par <= PARITY_ODD;
                    end
                    RX_DATA: begin
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_par   <= r_par ^ w_rx_s;
                    end
                    RX_PARITY: begin
                        r_perr <= (w_rx_s != r_par);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Frame completion takes priority over read: a read on the same edge
    // only suppresses the overrun indication for the incoming byte.
    always_ff @(posedge mclkx16) begin
        if (reset) begin
            r_data       <= '0;
            r_rxrdy      <= 1'b0;
            r_parityerr  <= 1'b0;
            r_framingerr <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_frame_done) begin
            r_data       <= r_shift;
            r_rxrdy      <= 1'b1;
            r_parityerr  <= r_perr;
            r_framingerr <= !w_rx_s;
            r_overrun    <= (r_overrun | r_rxrdy) & !read;
        end else if (read && r_rxrdy) begin
            r_rxrdy      <= 1'b0;
            r_parityerr  <= 1'b0;
            r_framingerr <= 1'b0;
            r_overrun    <= 1'b0;
        end
    end

    assign data       = r_data;
    assign rxrdy      = r_rxrdy;
    assign parityerr  = r_parityerr;
    assign framingerr = r_framingerr;
    assign overrun    = r_overrun;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, the downstream partner of `uart_tx`: recovers 11-bit frames (start, 8 data LSB-first, odd parity, stop) from the serial line at 16× oversampling on `mclkx16`. It presents each byte in a receive holding register with a ready flag and per-frame error flags. The host consumes the byte with a single-cycle read strobe. In loopback it pairs directly with `uart_tx` on the same `mclkx16`.

## Interface
- `OVERSAMPLE`, 16: `mclkx16` cycles per bit; matches the `uart_tx` bit period.
- `PARITY_ODD`, 1: 1 = odd parity (the `uart_tx` frame), 0 = even.
- `mclkx16` in 1: single clock, 16× baud.
- `reset` in 1: synchronous, active-high.
- `rx` in 1: asynchronous serial input; idle high.
- `read` in 1: single-cycle strobe, synchronous to `mclkx16`; consumes the held byte.
- `data` out 8: receive holding register (RHR).
- `rxrdy` out 1: RHR holds an unread byte.
- `parityerr` out 1: parity mismatch on the byte in RHR.
- `framingerr` out 1: stop bit sampled 0 on the byte in RHR.
- `overrun` out 1: a completed frame overwrote an unread byte.

## Operation
- Input path: two-flop synchronizer on `rx` produces `rx_s`, which has a 2-cycle latency. Synchronizer flops reset to 1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE
  - Tick counter is held at 0.
  - When `rx_s`=0 at edge d, go to START.
- Sampling
  - The tick counter is 4-bit and wraps at 15.
  - Bit k (0=start, 1..8=D0..D7, 9=parity, 10=stop) is sampled at edge d+8+16k, i.e. at mid-bit.
- START
  - Sample = 1: glitch; return to IDLE with no flag change.
  - Sample = 0: go to DATA.
- DATA
  - Shift the sample into the MSB of the shift register, so the byte is LSB-first.
  - Running parity is `PARITY_ODD` XOR all data bits.
  - After 8 samples, go to PARITY.
- PARITY
  - `perr` = sample ≠ running parity.
  - Go to STOP.
- STOP, at the stop-sample edge:
  - `data` ← shift register.
  - `rxrdy` ← 1.
  - `parityerr` ← `perr`.
  - `framingerr` ← (sample==0).
  - `overrun` ← `rxrdy` && !`read` (OR-held until read).
  - Next state is IDLE if sample = 1, else BREAK.
- BREAK: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Read
  - `read`=1 clears `rxrdy`, `parityerr`, `framingerr` and `overrun` at that edge.
  - `read` while `rxrdy`=0 has no effect.
  - `data` is never cleared by read.

## Timing
- Reset values:
  - `data`=0x00, all flags 0.
  - State IDLE, tick counter 0, shift register 0.
  - Synchronizer flops 1.
- Reset mid-frame aborts the frame immediately; no flag update.
- Latency:
  - Raw `rx` falling edge to detection (edge d): 2 cycles.
  - Detection to outputs updated: 168 cycles (edge d+168).
  - Outputs are valid in the cycle after edge d+168.
- Re-arm: IDLE is entered at d+168. A new start bit can be detected from edge d+169, so back-to-back `uart_tx` frames are received without loss.
- Simultaneous `read` and frame completion on the same edge:
  - The new byte loads and `rxrdy` stays 1.
  - `overrun` stays 0.
  - Error flags reflect the new frame.
- Frame completion while `rxrdy`=1 without `read`:
  - `data` is overwritten.
  - `overrun`=1 and remains 1 until read.
- `read` has no effect on the receive state machine.

## Structure
- Package `uart_pkg` holds:
  - `rx_state_t` enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - `OVERSAMPLE`=16, `SAMPLE_POINT`=7, `DATA_BITS`=8.
  - Frame bit-index constants.
- Sub-module `uart_sync`: parameterized N-flop synchronizer (N=2) with a reset value parameter (1 for `rx`).
- Top contains the FSM, tick and bit counters, shift register and RHR/flag logic.

## Test plan
- Loopback with `uart_tx`:
  - Write 0xA5 → frame start,1,0,1,0,0,1,0,1, parity 1, stop.
  - Required: `rxrdy`=1, `data`=0xA5, all error flags 0.
  - `read` pulse → `rxrdy`=0 next cycle.
- Glitch rejection: `rx` low for 4 cycles from idle → no `rxrdy`; FSM back in IDLE by detection+8.
- Parity error: drive 0x3C with parity bit 0 → `data`=0x3C, `parityerr`=1, `framingerr`=0.
- Framing and break:
  - Drive 0x00 with stop=0, then hold `rx` low for 40 bit times → exactly one frame, `framingerr`=1.
  - Release high and send 0x55 → second byte received normally.
- Overrun: two back-to-back frames 0x11 then 0x22 with no read → `data`=0x22, `overrun`=1. A read clears all flags.
- Reset and simultaneous events:
  - Assert `reset` at detection+80 → all outputs at reset values; the next full frame 0x7E is received correctly.
  - `read` on the completion edge of a second frame → `rxrdy`=1, `overrun`=0.
